// File: rtl/picorv32_write_buffer.sv
// Posted-write buffer in front of the AHB adapter.
// Writes ack on FIFO entry; reads wait for the FIFO to drain.
module picorv32_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_mem_valid,
  input  logic                    cpu_mem_instr,
  input  logic [31:0]             cpu_mem_addr,
  input  logic [31:0]             cpu_mem_wdata,
  input  logic [3:0]              cpu_mem_wstrb,
  output logic                    cpu_mem_ready,
  output logic [31:0]             cpu_mem_rdata,
  output logic                    mem_valid,
  output logic                    mem_instr,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata,
  output logic [$clog2(DEPTH):0]  wbuf_count,
  output logic                    wbuf_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    U_IDLE, U_WACK, U_RWAIT
  } u_state_t;

  typedef enum logic [1:0] {
    D_IDLE, D_WR, D_RD, D_RESP
  } d_state_t;

  u_state_t u_state, u_next;
  d_state_t d_state, d_next;

  logic [31:0] f_addr  [DEPTH];
  logic [31:0] f_wdata [DEPTH];
  logic [3:0]  f_wstrb [DEPTH];
  logic        f_instr [DEPTH];

  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic          empty_n;

  logic [31:0] rd_addr, rd_addr_n;
  logic        rd_instr, rd_instr_n;
  logic [31:0] rd_data, rd_data_n;

  logic        cpu_ready_n;
  logic [31:0] cpu_rdata_n;
  logic        mvalid_n;
  logic        minstr_n;
  logic [31:0] maddr_n;
  logic [31:0] mwdata_n;
  logic [3:0]  mwstrb_n;

  logic take;
  logic push;
  logic rd_acc;
  logic pop;

  // Request acceptance; full uses the registered count only
  always_comb begin
    take   = (u_state == U_IDLE) && !cpu_mem_ready && cpu_mem_valid;
    push   = take && (cpu_mem_wstrb != 4'h0) && (wbuf_count != FULL);
    rd_acc = take && (cpu_mem_wstrb == 4'h0);
    pop    = (d_state == D_WR) && mem_ready;
  end

  // FIFO storage, only written on push
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr]  <= cpu_mem_addr;
      f_wdata[wr_ptr] <= cpu_mem_wdata;
      f_wstrb[wr_ptr] <= cpu_mem_wstrb;
      f_instr[wr_ptr] <= cpu_mem_instr;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_n = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = wbuf_count;
    unique case ({push, pop})
      2'b10:   count_n = wbuf_count + 1'b1;
      2'b01:   count_n = wbuf_count - 1'b1;
      default: count_n = wbuf_count;
    endcase
    empty_n = (count_n == '0);
  end

  // Upstream FSM: write ack, read latch and read response
  always_comb begin
    u_next      = u_state;
    cpu_ready_n = 1'b0;
    cpu_rdata_n = cpu_mem_rdata;
    rd_addr_n   = rd_addr;
    rd_instr_n  = rd_instr;
    unique case (u_state)
      U_IDLE: begin
        if (push) begin
          u_next      = U_WACK;
          cpu_ready_n = 1'b1;
        end else if (rd_acc) begin
          u_next     = U_RWAIT;
          rd_addr_n  = cpu_mem_addr;
          rd_instr_n = cpu_mem_instr;
        end
      end
      U_WACK: u_next = U_IDLE;
      U_RWAIT: begin
        if (d_state == D_RESP) begin
          u_next      = U_IDLE;
          cpu_ready_n = 1'b1;
          cpu_rdata_n = rd_data;
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  // Downstream FSM: drain writes first, then the pending read
  always_comb begin
    d_next    = d_state;
    mvalid_n  = mem_valid;
    minstr_n  = mem_instr;
    maddr_n   = mem_addr;
    mwdata_n  = mem_wdata;
    mwstrb_n  = mem_wstrb;
    rd_data_n = rd_data;
    unique case (d_state)
      D_IDLE: begin
        if (wbuf_count != '0) begin
          d_next   = D_WR;
          mvalid_n = 1'b1;
          maddr_n  = f_addr[rd_ptr];
          mwdata_n = f_wdata[rd_ptr];
          mwstrb_n = f_wstrb[rd_ptr];
          minstr_n = f_instr[rd_ptr];
        end else if (u_state == U_RWAIT) begin
          d_next   = D_RD;
          mvalid_n = 1'b1;
          maddr_n  = rd_addr;
          mwdata_n = 32'h0;
          mwstrb_n = 4'h0;
          minstr_n = rd_instr;
        end
      end
      D_WR: begin
        if (mem_ready) begin
          d_next   = D_IDLE;
          mvalid_n = 1'b0;
        end
      end
      D_RD: begin
        if (mem_ready) begin
          d_next    = D_RESP;
          mvalid_n  = 1'b0;
          rd_data_n = mem_rdata;
        end
      end
      D_RESP:  d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      u_state       <= U_IDLE;
      d_state       <= D_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wbuf_count    <= '0;
      wbuf_empty    <= 1'b1;
      rd_addr       <= 32'h0;
      rd_instr      <= 1'b0;
      rd_data       <= 32'h0;
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= 32'h0;
      mem_valid     <= 1'b0;
      mem_instr     <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_wstrb     <= 4'h0;
    end else begin
      u_state       <= u_next;
      d_state       <= d_next;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      wbuf_count    <= count_n;
      wbuf_empty    <= empty_n;
      rd_addr       <= rd_addr_n;
      rd_instr      <= rd_instr_n;
      rd_data       <= rd_data_n;
      cpu_mem_ready <= cpu_ready_n;
      cpu_mem_rdata <= cpu_rdata_n;
      mem_valid     <= mvalid_n;
      mem_instr     <= minstr_n;
      mem_addr      <= maddr_n;
      mem_wdata     <= mwdata_n;
      mem_wstrb     <= mwstrb_n;
    end
  end

endmodule

// File: tb/tb_picorv32_write_buffer.sv
// Bench for picorv32_write_buffer.
// Scoreboard of expected downstream requests and read data.
module tb_picorv32_write_buffer;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   reset;
  logic                   cpu_mem_valid;
  logic                   cpu_mem_instr;
  logic [31:0]            cpu_mem_addr;
  logic [31:0]            cpu_mem_wdata;
  logic [3:0]             cpu_mem_wstrb;
  logic                   cpu_mem_ready;
  logic [31:0]            cpu_mem_rdata;
  logic                   mem_valid;
  logic                   mem_instr;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wstrb;
  logic                   mem_ready;
  logic [31:0]            mem_rdata;
  logic [$clog2(DEPTH):0] wbuf_count;
  logic                   wbuf_empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] rd_exp[$];

  int total = 0;
  int bad   = 0;

  picorv32_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_mem_valid (cpu_mem_valid),
    .cpu_mem_instr (cpu_mem_instr),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_mem_wstrb (cpu_mem_wstrb),
    .cpu_mem_ready (cpu_mem_ready),
    .cpu_mem_rdata (cpu_mem_rdata),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .wbuf_count    (wbuf_count),
    .wbuf_empty    (wbuf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic i);
    req_t r;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = a;
    cpu_mem_wdata = d;
    cpu_mem_wstrb = s;
    cpu_mem_instr = i;
    r.addr  = a;
    r.wdata = (s != 4'h0) ? d : 32'h0;
    r.wstrb = s;
    r.instr = i;
    exp_q.push_back(r);
  endtask

  task automatic cpu_idle();
    cpu_mem_valid = 1'b0;
    cpu_mem_wstrb = 4'h0;
    cpu_mem_instr = 1'b0;
  endtask

  task automatic wait_cpu_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (cpu_mem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mem_valid(input int max, output bit ok);
    ok = (mem_valid === 1'b1);
    for (int k = 0; k < max && !ok; k++) begin
      tick();
      ok = (mem_valid === 1'b1);
    end
  endtask

  task automatic serve(input int lat, input logic [31:0] rd, output bit ok,
                       output req_t got, output logic emp);
    wait_mem_valid(50, ok);
    got.addr  = mem_addr;
    got.wdata = mem_wdata;
    got.wstrb = mem_wstrb;
    got.instr = mem_instr;
    emp       = wbuf_empty;
    if (!ok) return;
    repeat (lat - 1) tick();
    mem_rdata = rd;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({cpu_mem_ready, cpu_mem_rdata, mem_valid, mem_instr, mem_addr,
         mem_wdata, mem_wstrb, wbuf_count} !== '0 || wbuf_empty !== 1'b1)
      begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b count=%0d empty=%b want 0/0/0/1",
               cpu_mem_ready, mem_valid, wbuf_count, wbuf_empty);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    req_t g, e;
    logic emp;
    cpu_drive(32'h8000_0000, 32'hF0FF_0FAA, 4'b1100, 1'b0);
    tick();
    total++;
    if (cpu_mem_ready !== 1'b1 || wbuf_count !== 1) begin
      bad++;
      $display("FAIL wr_ack: ready=%b count=%0d want 1/1", cpu_mem_ready, wbuf_count);
    end
    cpu_idle();
    tick();
    total++;
    if (cpu_mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL wr_ack_pulse: ready=%b want 0", cpu_mem_ready);
    end
    serve(1, 32'h0, ok, g, emp);
    e = exp_q.pop_front();
    total++;
    if (!ok || g.addr !== e.addr || g.wdata !== e.wdata ||
        g.wstrb !== e.wstrb || g.instr !== e.instr) begin
      bad++;
      $display("FAIL wr_fwd: ok=%b got %h/%h/%h/%b want %h/%h/%h/%b", ok,
               g.addr, g.wdata, g.wstrb, g.instr, e.addr, e.wdata, e.wstrb, e.instr);
    end
    total++;
    if (wbuf_count !== 0 || mem_valid !== 1'b0 || wbuf_empty !== 1'b1) begin
      bad++;
      $display("FAIL wr_drain: count=%0d valid=%b empty=%b want 0/0/1",
               wbuf_count, mem_valid, wbuf_empty);
    end
  endtask

  task automatic test_read(input logic [31:0] a, input logic i,
                           input logic [31:0] rd);
    req_t e;
    logic [31:0] er;
    cpu_drive(a, 32'h0, 4'h0, i);
    tick();
    total++;
    if (mem_valid !== 1'b0 || cpu_mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL rd_latch: valid=%b ready=%b want 0/0", mem_valid, cpu_mem_ready);
    end
    tick();
    e = exp_q.pop_front();
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== e.addr || mem_wstrb !== 4'h0 ||
        mem_instr !== e.instr) begin
      bad++;
      $display("FAIL rd_launch: valid=%b addr=%h wstrb=%h instr=%b want 1/%h/0/%b",
               mem_valid, mem_addr, mem_wstrb, mem_instr, e.addr, e.instr);
    end
    repeat (2) tick();
    mem_rdata = rd;
    mem_ready = 1'b1;
    rd_exp.push_back(rd);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    total++;
    if (cpu_mem_ready !== 1'b0 || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp_stage: ready=%b valid=%b want 0/0",
               cpu_mem_ready, mem_valid);
    end
    tick();
    er = rd_exp.pop_front();
    total++;
    if (cpu_mem_ready !== 1'b1 || cpu_mem_rdata !== er) begin
      bad++;
      $display("FAIL rd_data: ready=%b rdata=%h want 1/%h",
               cpu_mem_ready, cpu_mem_rdata, er);
    end
    cpu_idle();
    tick();
    total++;
    if (cpu_mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL rd_ack_pulse: ready=%b want 0", cpu_mem_ready);
    end
  endtask

  task automatic test_full();
    bit ok;
    bit acked;
    req_t g, e;
    logic emp;
    mem_ready = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin
      cpu_drive(32'(n * 4), 32'h1000 + 32'(n), 4'hF, 1'b0);
      wait_cpu_ready(4, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL full_ack%0d: ready=%b want 1", n, cpu_mem_ready);
      end
    end
    total++;
    if (wbuf_count !== DEPTH) begin
      bad++;
      $display("FAIL full_count: count=%0d want %0d", wbuf_count, DEPTH);
    end
    cpu_drive(32'h10, 32'h1004, 4'hF, 1'b0);
    acked = 1'b0;
    repeat (4) begin
      tick();
      if (cpu_mem_ready === 1'b1) acked = 1'b1;
    end
    total++;
    if (acked || wbuf_count !== DEPTH) begin
      bad++;
      $display("FAIL full_stall: acked=%b count=%0d want 0/%0d",
               acked, wbuf_count, DEPTH);
    end
    serve(1, 32'h0, ok, g, emp);
    e = exp_q.pop_front();
    total++;
    if (!ok || g.addr !== e.addr || g.wdata !== e.wdata) begin
      bad++;
      $display("FAIL full_first: ok=%b got %h/%h want %h/%h",
               ok, g.addr, g.wdata, e.addr, e.wdata);
    end
    total++;
    if (cpu_mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_edge: ready=%b want 0", cpu_mem_ready);
    end
    tick();
    total++;
    if (cpu_mem_ready !== 1'b1 || wbuf_count !== DEPTH) begin
      bad++;
      $display("FAIL full_late_ack: ready=%b count=%0d want 1/%0d",
               cpu_mem_ready, wbuf_count, DEPTH);
    end
    cpu_idle();
    for (int n = 1; n <= DEPTH; n++) begin
      serve(2, 32'h0, ok, g, emp);
      e = exp_q.pop_front();
      total++;
      if (!ok || g.addr !== e.addr || g.wdata !== e.wdata ||
          g.wstrb !== e.wstrb) begin
        bad++;
        $display("FAIL full_order%0d: ok=%b got %h/%h want %h/%h",
                 n, ok, g.addr, g.wdata, e.addr, e.wdata);
      end
    end
    tick();
    total++;
    if (wbuf_empty !== 1'b1 || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_drained: empty=%b valid=%b want 1/0", wbuf_empty, mem_valid);
    end
  endtask

  task automatic test_read_after_write();
    bit ok;
    req_t g, e;
    logic emp;
    logic [31:0] er;
    mem_ready = 1'b0;
    cpu_drive(32'h20, 32'hCAFE_0001, 4'hF, 1'b0);
    wait_cpu_ready(4, ok);
    cpu_drive(32'h24, 32'hCAFE_0002, 4'h3, 1'b0);
    wait_cpu_ready(4, ok);
    cpu_drive(32'h0, 32'h0, 4'h0, 1'b0);
    rd_exp.push_back(32'h5555_AAAA);
    for (int k = 0; k < 3; k++) begin
      serve(2, 32'h5555_AAAA, ok, g, emp);
      e = exp_q.pop_front();
      total++;
      if (!ok || g.addr !== e.addr || g.wstrb !== e.wstrb ||
          (e.wstrb != 4'h0 && g.wdata !== e.wdata) ||
          (g.wstrb === 4'h0 && emp !== 1'b1)) begin
        bad++;
        $display("FAIL raw_order%0d: ok=%b got %h/%h empty=%b want %h/%h",
                 k, ok, g.addr, g.wstrb, emp, e.addr, e.wstrb);
      end
    end
    wait_cpu_ready(4, ok);
    er = rd_exp.pop_front();
    total++;
    if (!ok || cpu_mem_rdata !== er) begin
      bad++;
      $display("FAIL raw_data: ok=%b rdata=%h want %h", ok, cpu_mem_rdata, er);
    end
    cpu_idle();
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    req_t g, e;
    logic emp;
    mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cpu_drive(32'h30 + 32'(n * 4), 32'h7700 + 32'(n), 4'hF, 1'b0);
      wait_cpu_ready(4, ok);
    end
    cpu_idle();
    wait_mem_valid(10, ok);
    total++;
    if (!ok || wbuf_count !== 3) begin
      bad++;
      $display("FAIL rst_pre: valid=%b count=%0d want 1/3", mem_valid, wbuf_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (mem_valid !== 1'b0 || cpu_mem_ready !== 1'b0 || wbuf_count !== 0 ||
        wbuf_empty !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: valid=%b ready=%b count=%0d empty=%b want 0/0/0/1",
               mem_valid, cpu_mem_ready, wbuf_count, wbuf_empty);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    total++;
    if (mem_valid !== 1'b0 || cpu_mem_ready !== 1'b0 || wbuf_count !== 0) begin
      bad++;
      $display("FAIL rst_late_ready: valid=%b ready=%b count=%0d want 0/0/0",
               mem_valid, cpu_mem_ready, wbuf_count);
    end
    cpu_drive(32'h40, 32'h1234_5678, 4'h1, 1'b0);
    wait_cpu_ready(4, ok);
    cpu_idle();
    serve(1, 32'h0, ok, g, emp);
    e = exp_q.pop_front();
    total++;
    if (!ok || g.addr !== e.addr || g.wdata !== e.wdata || g.wstrb !== e.wstrb)
      begin
      bad++;
      $display("FAIL rst_recover: ok=%b got %h/%h/%h want %h/%h/%h", ok,
               g.addr, g.wdata, g.wstrb, e.addr, e.wdata, e.wstrb);
    end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    cpu_mem_valid = 1'b0;
    cpu_mem_instr = 1'b0;
    cpu_mem_addr  = 32'h0;
    cpu_mem_wdata = 32'h0;
    cpu_mem_wstrb = 4'h0;
    mem_ready     = 1'b0;
    mem_rdata     = 32'h0;
    test_reset();
    test_single_write();
    test_read(32'h8000_0000, 1'b0, 32'hAAAA_FFFF);
    test_full();
    test_read_after_write();
    test_mid_reset();
    test_read(32'h0000_0100, 1'b1, 32'h0000_0013);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picorv32_write_buffer.md
Name: picorv32_write_buffer

Overview:
Posted-write buffer between the PicoRV32 native memory interface and the picorv32_freeahb_adapter.
- Writes are acknowledged to the core as soon as they enter an in-order FIFO, so the core does not stall on AHB write latency.
- Reads and instruction fetches are forwarded only after every buffered write has completed downstream, which preserves program order.
- Both sides use the PicoRV32 native valid/ready protocol.

Parameters:
DEPTH, 4, number of write FIFO entries; power of two, ≥2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_mem_valid  in  1  core request valid, held until cpu_mem_ready
cpu_mem_instr  in  1  request is an instruction fetch
cpu_mem_addr  in  32  request address
cpu_mem_wdata  in  32  write data
cpu_mem_wstrb  in  4  byte strobes; 0 = read
cpu_mem_ready  out  1  one-cycle completion pulse to core
cpu_mem_rdata  out  32  read data, valid while cpu_mem_ready=1
mem_valid  out  1  request to adapter
mem_instr  out  1  forwarded instr flag
mem_addr  out  32  forwarded address
mem_wdata  out  32  forwarded write data
mem_wstrb  out  4  forwarded strobes
mem_ready  in  1  adapter completion pulse
mem_rdata  in  32  adapter read data, valid with mem_ready
wbuf_count  out  $clog2(DEPTH)+1  entries currently buffered
wbuf_empty  out  1  wbuf_count==0

Behaviour:
Protocol and reset:
- All outputs are registered.
- Reset values: all outputs 0, wbuf_empty=1.
- Reset clears the FIFO, both FSMs and all latched request fields. An in-flight downstream transaction is abandoned: mem_valid=0 from the cycle after the reset edge, and any later mem_ready for it is ignored. Buffered writes are discarded.
- Upstream requests are sampled only when cpu_mem_ready=0 and the upstream FSM is in U_IDLE. The core's still-high valid during the ack cycle is never re-accepted.

Upstream FSM (U_IDLE, U_WACK, U_RWAIT):
- U_IDLE, cpu_mem_valid=1, wstrb≠0, count<DEPTH: push {addr,wdata,wstrb,instr} at this edge. Go to U_WACK, with cpu_mem_ready=1 for the next cycle only. Write latency is 1 cycle.
- U_IDLE, write with count==DEPTH: stall, no ack, re-evaluate each cycle. Full is taken from the registered count, so a pop on the same edge does not free a slot until the following cycle.
- U_WACK returns to U_IDLE after one cycle.
- U_IDLE, cpu_mem_valid=1, wstrb==0: latch addr/instr, raise a read request, go to U_RWAIT.
- U_RWAIT: wait until the downstream FSM reaches D_RESP. Then cpu_mem_ready=1 and cpu_mem_rdata=latched data for one cycle, and return to U_IDLE.
- cpu_mem_rdata holds its last value otherwise and is don't-care when cpu_mem_ready=0.

Downstream FSM (D_IDLE, D_WR, D_RD, D_RESP):
- D_IDLE, FIFO non-empty: load the FIFO head into mem_*, assert mem_valid, go to D_WR. Writes have priority.
- D_IDLE, FIFO empty and read pending: drive the read fields with mem_wstrb=0, assert mem_valid, go to D_RD.
- D_WR, on mem_ready: pop, drop mem_valid, go to D_IDLE.
- D_RD, on mem_ready: latch mem_rdata, drop mem_valid, go to D_RESP.
- D_RESP returns to D_IDLE after one cycle.
- mem_valid is low for at least one cycle between transactions.
- mem_* fields stay stable while mem_valid=1.
- mem_ready while mem_valid=0 is ignored.

Ordering and read latency:
- A read never issues while the FIFO is non-empty or while D_WR is active.
- A read's downstream mem_valid rises 1 cycle after its latch edge when the FIFO is empty (the FIFO-empty condition covers D_WR being active).
- Read latency with an empty FIFO = 1 (launch) + downstream latency + 1 (response).

FIFO:
- Read/write pointers wrap modulo DEPTH.
- Push and pop on the same edge leave the count unchanged.
- Entries drain strictly in push order.

Test Plan:
1. Single write: cpu addr 0x8000_0000, wdata 0xF0FF_0FAA, wstrb 4'b1100 → cpu_mem_ready pulses the cycle after valid and wbuf_count=1; mem_valid then appears with identical fields; mem_ready → wbuf_count=0, mem_valid=0.
2. Read with empty buffer: addr 0x8000_0000, wstrb 0 → mem_valid with mem_wstrb=0; adapter returns mem_rdata 0xAAAA_FFFF after 3 cycles → cpu_mem_ready=1 with cpu_mem_rdata 0xAAAA_FFFF exactly 1 cycle after mem_ready.
3. Full (DEPTH=4), mem_ready held 0: 5 back-to-back writes to 0x0,0x4,…,0x10 → 4 acked, wbuf_count=4, 5th stalled. Release mem_ready → writes appear on mem_* in order 0x0..0x10, and the 5th is acked one cycle after the first pop.
4. Read-after-write: two writes then a read to 0x0 → mem_valid for the read rises only after both write mem_ready pulses; no read while wbuf_empty=0.
5. Reset mid-operation: 3 entries buffered, D_WR active, reset high 1 cycle → next cycle mem_valid=0, cpu_mem_ready=0, wbuf_count=0; a late mem_ready produces no pop or ack.
6. Instruction fetch: cpu_mem_instr=1, wstrb=0, addr 0x0000_0100 → forwarded with mem_instr=1 and the same addr; data returned as in scenario 2.
